// File: rtl/seq_divider_32.sv
// Sequential radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU path.
// One quotient bit per CALC cycle; signs are stripped on accept and restored in FIX.
module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             signed_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and the producer holds its data
  // stable while valid is high and ready is low.

  state_e           state_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic             accept;
  logic             div_zero;
  logic             sgn_ovf;
  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] rem_low;
  logic             unused_rem_msb;

  assign accept   = in_valid_i && (state_q == IDLE);
  assign div_zero = (divisor_i == '0);
  assign sgn_ovf  = signed_i && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
                             && (divisor_i == {WIDTH{1'b1}});

  assign dividend_abs = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
  assign divisor_abs  = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

  // The partial remainder is always below the divisor, so its top bit only
  // matters transiently inside the shifted value, never in the stored one.
  assign rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dvsr_q});
  assign rem_diff  = rem_shift - {1'b0, dvsr_q};
  assign rem_d     = rem_ge ? rem_diff : rem_shift;
  assign quo_d     = {quo_q[WIDTH-2:0], rem_ge};
  assign rem_low   = rem_q[WIDTH-1:0];
  assign unused_rem_msb = rem_q[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (div_zero) begin
              quotient_q  <= {WIDTH{1'b1}};
              remainder_q <= dividend_i;
              state_q     <= DONE;
            end else if (sgn_ovf) begin
              quotient_q  <= {1'b1, {(WIDTH-1){1'b0}}};
              remainder_q <= '0;
              state_q     <= DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= dividend_abs;
              dvsr_q  <= divisor_abs;
              cnt_q   <= CNT_W'(WIDTH);
              neg_q_q <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
              neg_r_q <= signed_i && dividend_i[WIDTH-1];
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quotient_q  <= neg_q_q ? -quo_q : quo_q;
          remainder_q <= neg_r_q ? -rem_low : rem_low;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Bench for seq_divider_32: directed RISC-V corner cases plus randomized
// operations checked against an arithmetic reference model.
module tb_seq_divider_32;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         signed_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         out_valid_o;
  logic         out_ready_i;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*W-1:0] exp_q[$];

  seq_divider_32 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .signed_i    (signed_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic is_special(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    return (b == 0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V division semantics; SV signed / and % truncate toward zero.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q = sa / sb;
      r = sa % sb;
      return {q[W-1:0], r[W-1:0]};
    end
    return {a / b, a % b};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return $urandom_range(0, 15);
      5: return -$urandom_range(1, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for the result, stall, then retire it.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int stall);
    int w, lat;
    logic [2*W-1:0] exp;
    exp_q.push_back(ref_div(a, b, s));
    w = 0;
    while (!in_ready_o && w < 100) begin tick(); w++; end
    check("in_ready_before_op", {63'd0, in_ready_o}, 64'd1);
    dividend_i = a; divisor_i = b; signed_i = s; in_valid_i = 1'b1; out_ready_i = 1'b0;
    tick();
    in_valid_i = 1'b0;
    dividend_i = $urandom; divisor_i = $urandom; signed_i = $urandom_range(0, 1);
    lat = 0;
    while (!out_valid_o && lat < 100) begin tick(); lat++; end
    check("latency", 64'(lat), is_special(a, b, s) ? 64'd0 : 64'(W + 1));
    repeat (stall) tick();
    exp = exp_q.pop_front();
    check("quotient", {32'd0, quotient_o}, {32'd0, exp[2*W-1:W]});
    check("remainder", {32'd0, remainder_o}, {32'd0, exp[W-1:0]});
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("retire", {62'd0, in_ready_o, out_valid_o}, 64'b10);
  endtask

  initial begin
    logic [W-1:0] hq, hr;
    logic stable;
    rst = 1'b1; dividend_i = '0; divisor_i = '0; signed_i = 1'b0;
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    #1;
    check("reset_state", {in_ready_o, out_valid_o, 30'd0, quotient_o | remainder_o}, {1'b1, 1'b0, 62'd0});
    repeat (2) tick();
    rst = 1'b0;
    tick();

    run_op(32'd100, 32'd7, 1'b0, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_op(32'd5, 32'd0, 1'b0, 0);
    run_op(32'd5, 32'd0, 1'b1, 2);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'h8000_0000, 32'd1, 1'b1, 0);

    // Backpressure: results frozen in DONE while in_valid_i is offered.
    dividend_i = 32'd1000; divisor_i = 32'd33; signed_i = 1'b0; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    repeat (W + 1) tick();
    check("bp_valid", {63'd0, out_valid_o}, 64'd1);
    hq = quotient_o; hr = remainder_o; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dividend_i = $urandom; divisor_i = $urandom; in_valid_i = 1'b1;
      tick();
      if (quotient_o !== hq || remainder_o !== hr || !out_valid_o || in_ready_o) stable = 1'b0;
    end
    in_valid_i = 1'b0;
    check("bp_stable", {63'd0, stable}, 64'd1);
    check("bp_result", {quotient_o, remainder_o}, {32'd30, 32'd10});
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("bp_release", {62'd0, in_ready_o, out_valid_o}, 64'b10);
    run_op(32'd81, 32'd9, 1'b0, 0);

    // Reset 10 cycles into an operation discards it immediately.
    dividend_i = 32'h1234_5678; divisor_i = 32'd3; signed_i = 1'b0; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("mid_reset", {in_ready_o, out_valid_o, 30'd0, quotient_o | remainder_o}, {1'b1, 1'b0, 62'd0});
    tick();
    rst = 1'b0;
    tick();
    run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 0);

    for (int n = 0; n < 1400; n++) begin
      run_op(pick(), pick(), 1'(($urandom_range(0, 1))), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
